// File: rtl/generation_counter.sv
// Generation counter for the seven-segment display: counts engine generations and owns run/pause.
// Define GENERATION_COUNTER_WRAP_EN to wrap MAX_COUNT -> 0 instead of saturating.

module generation_counter_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_WIDTH        = 20
) (
    input  logic clock_100,
    input  logic reset,
    input  logic btn_raw,
    output logic press_evt
);

    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                level_q, level_d;
    logic [DB_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        // The count only advances while the synchronized sample disagrees with the accepted level.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            level_d   = ~level_q;
            cnt_d     = '0;
            press_evt = ~level_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

module generation_counter #(
    parameter int MAX_COUNT       = 9999,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_WIDTH        = 20
) (
    input  logic        clock_100,
    input  logic        reset,
    input  logic        gen_done,
    input  logic        btn_pause,
    input  logic        btn_clear,
    output logic [13:0] num,
    output logic        running,
    output logic        saturated
);

    localparam logic [13:0] MAX_NUM = 14'(MAX_COUNT);

`ifdef GENERATION_COUNTER_WRAP_EN
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        SAT   = 2'd2
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [13:0] num_q, num_d;
    logic        gen_done_q, gen_done_d;
    logic        pause_evt;
    logic        clear_evt;
    logic        gen_edge;
    logic [13:0] num_inc;

    generation_counter_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_WIDTH       (DB_WIDTH)
    ) u_db_pause (
        .clock_100(clock_100),
        .reset    (reset),
        .btn_raw  (btn_pause),
        .press_evt(pause_evt)
    );

    generation_counter_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_WIDTH       (DB_WIDTH)
    ) u_db_clear (
        .clock_100(clock_100),
        .reset    (reset),
        .btn_raw  (btn_clear),
        .press_evt(clear_evt)
    );

    assign gen_edge = gen_done & ~gen_done_q;
    assign num_inc  = num_q + 14'd1;

    always_comb begin
        gen_done_d = gen_done;
        state_d    = state_q;
        num_d      = num_q;
        case (state_q)
            RUN: begin
                if (gen_edge) begin
`ifdef GENERATION_COUNTER_WRAP_EN
                    num_d = (num_q == MAX_NUM) ? 14'd0 : num_inc;
`else
                    num_d = num_inc;
                    if (num_inc == MAX_NUM) begin
                        state_d = SAT;
                    end
`endif
                end
                // Saturation outranks a simultaneous pause toggle.
                if (pause_evt && (state_d == RUN)) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_evt) begin
                    state_d = RUN;
                end
            end
`ifndef GENERATION_COUNTER_WRAP_EN
            SAT: begin
                state_d = SAT;
            end
`endif
            default: begin
                state_d = PAUSE;
                num_d   = 14'd0;
            end
        endcase
        // Clear drops any same-cycle edge but still honours a pause toggle outside SAT.
        if (clear_evt) begin
            num_d = 14'd0;
            if (state_q == RUN) begin
                state_d = pause_evt ? PAUSE : RUN;
            end else if (state_q == PAUSE) begin
                state_d = pause_evt ? RUN : PAUSE;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            state_q    <= PAUSE;
            num_q      <= 14'd0;
            gen_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            gen_done_q <= gen_done_d;
        end
    end

    assign num     = num_q;
    assign running = (state_q == RUN);
`ifdef GENERATION_COUNTER_WRAP_EN
    assign saturated = 1'b0;
`else
    assign saturated = (state_q == SAT);
`endif

endmodule

// File: tb/tb_generation_counter.sv
// Self-checking bench for generation_counter: directed plan, vector table, and randomized
// stimulus against a behavioural model of the counter and button rules.

module tb_generation_counter;

    localparam int MAXC = 12;
    localparam int DB   = 4;

    logic        clock_100 = 1'b0;
    logic        reset     = 1'b1;
    logic        gen_done  = 1'b0;
    logic        btn_pause = 1'b0;
    logic        btn_clear = 1'b0;
    logic [13:0] num;
    logic        running;
    logic        saturated;

    generation_counter #(
        .MAX_COUNT      (MAXC),
        .DEBOUNCE_CYCLES(DB),
        .DB_WIDTH       (20)
    ) dut (
        .clock_100(clock_100),
        .reset    (reset),
        .gen_done (gen_done),
        .btn_pause(btn_pause),
        .btn_clear(btn_clear),
        .num      (num),
        .running  (running),
        .saturated(saturated)
    );

    always #5 clock_100 = ~clock_100;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    typedef enum {M_RUN, M_PAUSE, M_SAT} mode_t;
    mode_t m_mode;
    int    m_num;
    bit    hp[$];
    bit    hc[$];
    bit    lvl[2];
    int    differ_run[2];
    bit    g_prev;

    typedef struct {
        int n_gen;
        int pause;
        int clear;
        int exp_num;
        int exp_run;
        int exp_sat;
    } vec_t;
    vec_t tbl[8];

    function void model_reset();
        m_mode = M_PAUSE;
        m_num  = 0;
        hp.delete(); hp.push_back(1'b0); hp.push_back(1'b0);
        hc.delete(); hc.push_back(1'b0); hc.push_back(1'b0);
        lvl[0] = 1'b0; lvl[1] = 1'b0;
        differ_run[0] = 0; differ_run[1] = 0;
        g_prev = 1'b0;
    endfunction

    // A level change is accepted after DB consecutive samples that disagree with it.
    function automatic bit debounced_press(int b, bit s);
        if (s != lvl[b]) differ_run[b] = differ_run[b] + 1;
        else differ_run[b] = 0;
        if (differ_run[b] == DB) begin
            lvl[b] = s;
            differ_run[b] = 0;
            return s;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        bit sp, sc, pe, ce, ge;
        if (reset) begin
            model_reset();
            return;
        end
        sp = hp.pop_front(); hp.push_back(btn_pause);
        sc = hc.pop_front(); hc.push_back(btn_clear);
        pe = debounced_press(0, sp);
        ce = debounced_press(1, sc);
        ge = gen_done && !g_prev;
        g_prev = gen_done;
        if (ce) begin
            m_num = 0;
            if (m_mode == M_SAT) m_mode = M_RUN;
            else if (pe) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
        end else if (m_mode == M_RUN) begin
            if (ge) begin
`ifdef GENERATION_COUNTER_WRAP_EN
                m_num = (m_num == MAXC) ? 0 : m_num + 1;
`else
                m_num = m_num + 1;
                if (m_num == MAXC) m_mode = M_SAT;
`endif
            end
            if (pe && m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (m_mode == M_PAUSE) begin
            if (pe) m_mode = M_RUN;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(bit g, bit p, bit c);
        gen_done  = g;
        btn_pause = p;
        btn_clear = c;
        model_step();
        @(posedge clock_100);
        #1;
        check("model_num", 32'(num), 32'(m_num));
        check("model_running", 32'(running), 32'(m_mode == M_RUN));
        check("model_saturated", 32'(saturated), 32'(m_mode == M_SAT));
    endtask

    task automatic pulses(int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Clean press held 8 cycles, then released 8; gen_done optionally high on cycle gen_at.
    task automatic press(bit p, bit c, int gen_at);
        for (int i = 0; i < 8; i++) cyc(i == gen_at, p, c);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
    endtask

    initial begin
        bit g, p, c;
        model_reset();

        tbl[0] = '{3,  0, 0, 0,  0, 0};
        tbl[1] = '{4,  1, 0, 4,  1, 0};
        tbl[2] = '{2,  0, 0, 6,  1, 0};
        tbl[3] = '{3,  1, 0, 6,  0, 0};
        tbl[4] = '{0,  0, 1, 0,  0, 0};
`ifdef GENERATION_COUNTER_WRAP_EN
        tbl[5] = '{20, 1, 0, 7,  1, 0};
`else
        tbl[5] = '{20, 1, 0, 12, 0, 1};
`endif
        tbl[6] = '{0,  0, 1, 0,  1, 0};
        tbl[7] = '{5,  0, 0, 5,  1, 0};

        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("reset_num", 32'(num), 0);
        check("reset_running", 32'(running), 0);
        check("reset_saturated", 32'(saturated), 0);
        #2 reset = 1'b0;

        pulses(3);
        check("paused_num", 32'(num), 0);
        check("paused_running", 32'(running), 0);

        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0);
        check("pause_press_running", 32'(running), 1);
        pulses(5);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("run_count_num", 32'(num), 6);

        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, ((i / 2) % 2) == 0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1);
        check("bouncy_clear_num", 32'(num), 0);
        check("bouncy_clear_running", 32'(running), 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0);
        pulses(2);
        check("single_clear_num", 32'(num), 2);

        press(1'b0, 1'b1, -1);
`ifdef GENERATION_COUNTER_WRAP_EN
        pulses(13);
        check("wrap_num", 32'(num), 0);
        check("wrap_saturated", 32'(saturated), 0);
        check("wrap_running", 32'(running), 1);
`else
        pulses(12);
        check("sat_num", 32'(num), 12);
        check("sat_saturated", 32'(saturated), 1);
        check("sat_running", 32'(running), 0);
        pulses(3);
        press(1'b1, 1'b0, -1);
        check("sat_hold_num", 32'(num), 12);
        check("sat_hold_saturated", 32'(saturated), 1);
        press(1'b0, 1'b1, -1);
        check("sat_clear_num", 32'(num), 0);
        check("sat_clear_running", 32'(running), 1);
        check("sat_clear_saturated", 32'(saturated), 0);
`endif

        press(1'b0, 1'b1, -1);
        pulses(5);
        press(1'b0, 1'b1, 5);
        check("clear_vs_edge_num", 32'(num), 0);
        check("clear_vs_edge_running", 32'(running), 1);
        pulses(5);
        press(1'b1, 1'b0, 5);
        check("pause_with_edge_num", 32'(num), 6);
        check("pause_with_edge_running", 32'(running), 0);
        press(1'b1, 1'b0, -1);
        check("resume_running", 32'(running), 1);

        pulses(3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_num", 32'(num), 0);
        check("async_reset_running", 32'(running), 0);
        check("async_reset_saturated", 32'(saturated), 0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
        check("held_through_reset_running", 32'(running), 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0);

        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].pause != 0) press(1'b1, 1'b0, -1);
            if (tbl[i].clear != 0) press(1'b0, 1'b1, -1);
            pulses(tbl[i].n_gen);
            check($sformatf("vec%0d_num", i), 32'(num), 32'(tbl[i].exp_num));
            check($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].exp_run));
            check($sformatf("vec%0d_saturated", i), 32'(saturated), 32'(tbl[i].exp_sat));
        end

        do_reset();
        g = 1'b0; p = 1'b0; c = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) g = ~g;
            if ($urandom_range(0, 9) == 0) p = ~p;
            if ($urandom_range(0, 24) == 0) c = ~c;
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b1;
                #1;
                check("rand_async_reset_num", 32'(num), 0);
                cyc(g, p, c);
                #2 reset = 1'b0;
            end
            cyc(g, p, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
